// File: rtl/regfile_wb_ctrl_pkg.sv
// rtl/regfile_wb_ctrl_pkg.sv - shared constants and types for the register-file write-port controller
package regfile_wb_ctrl_pkg;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LSU  = 1;
    localparam int REQ_MUL  = 2;

    localparam int RD_W     = 5;
    localparam int NUM_REGS = 32;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [RD_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// rtl/regfile_wb_ctrl_rr_arbiter.sv - round-robin grant over N_REQ requesters, pointer held inside
module regfile_wb_ctrl_rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [N_REQ-1:0]                          i_req,
    output logic [N_REQ-1:0]                          o_gnt,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] o_gnt_idx,
    output logic                                      o_gnt_any
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   w_cand;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_next;
    logic             w_any;

    always_comb begin
        w_cand = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        // Visit requesters starting at the pointer, wrapping modulo N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_cand >= (PTR_W+1)'(N_REQ))
                w_cand = w_cand - (PTR_W+1)'(N_REQ);
            if (!w_any && i_req[w_cand[PTR_W-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        o_gnt        = '0;
        o_gnt[w_idx] = w_any;
    end

    assign w_next    = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
    assign o_gnt_idx = w_idx;
    assign o_gnt_any = w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (w_any)
            r_ptr <= w_next;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - write-port arbitration and outstanding-write scoreboard for the 32x32 register file
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int CNT_W = 2,
    parameter int XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [5*N_REQ-1:0]      req_rd,
    input  logic [XLEN*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    output logic                    issue_ready,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    W_en,
    output logic [4:0]              Rd,
    output logic [XLEN-1:0]         Wr_data,
    output logic                    sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_xfer;
    reg_idx_t          w_sel_rd;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_inc;
    logic              w_dec;
    logic              w_same;
    logic              w_underflow;

    logic [CNT_W-1:0]  r_cnt [NUM_REGS];
    logic              r_wen;
    reg_idx_t          r_rd;
    logic [XLEN-1:0]   r_wdata;
    logic              r_sb_err;

    regfile_wb_ctrl_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req_valid),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_xfer)
    );

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd   = req_rd[i*RD_W +: RD_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign req_ready   = w_gnt;
    assign issue_ready = (issue_rd == '0) || (r_cnt[issue_rd] != CNT_MAX);
    assign w_inc       = issue_valid && issue_ready && (issue_rd != '0);
    assign w_dec       = w_xfer && (w_sel_rd != '0);
    // A same-register issue and retire cancel, so no underflow can come from that pair.
    assign w_same      = w_inc && w_dec && (issue_rd == w_sel_rd);
    assign w_underflow = w_dec && !w_same && (r_cnt[w_sel_rd] == '0);

    // Hazards look at the registered counters only; same-cycle retires are not forwarded.
    assign rs1_busy = (rs1 != '0) && (r_cnt[rs1] != '0);
    assign rs2_busy = (rs2 != '0) && (r_cnt[rs2] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_cnt[i] <= '0;
            r_sb_err <= 1'b0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_inc && !w_same && (issue_rd == RD_W'(i)))
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                else if (w_dec && !w_same && (w_sel_rd == RD_W'(i)) && (r_cnt[i] != '0))
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
            if (w_underflow)
                r_sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_rd    <= '0;
            r_wdata <= XLEN'(ZERO_WORD);
        end else begin
            r_wen <= w_xfer && (w_sel_rd != '0);
            if (w_xfer) begin
                r_rd    <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign W_en    = r_wen;
    assign Rd      = r_rd;
    assign Wr_data = r_wdata;
    assign sb_err  = r_sb_err;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;
    import regfile_wb_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        W_en;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;
    logic        sb_err;

    logic [31:0] rf [32];
    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .W_en(W_en), .Rd(Rd), .Wr_data(Wr_data), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (W_en) rf[Rd] <= Wr_data;

    task automatic set_req(input int idx, input logic [4:0] rd, input logic [31:0] data);
        req_rd[idx*5 +: 5]     = rd;
        req_data[idx*32 +: 32] = data;
        req_valid[idx]         = 1'b1;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_rd    = rd;
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        #3;
        n_tests++; if (W_en !== 1'b0)     begin n_fail++; $display("FAIL reset_wen got=%b exp=0", W_en); end
        n_tests++; if (Rd !== 5'd0)       begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", Rd); end
        n_tests++; if (Wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", Wr_data); end
        n_tests++; if (sb_err !== 1'b0)   begin n_fail++; $display("FAIL reset_sberr got=%b exp=0", sb_err); end
        n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_only;
        do_issue(5'd5);
        @(negedge clk);
        set_req(REQ_ALU, 5'd5, 32'hDEADBEEF);
        #1;
        n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL alu_ready got=%b exp=001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        n_tests++; if (W_en !== 1'b1)  begin n_fail++; $display("FAIL alu_wen got=%b exp=1", W_en); end
        n_tests++; if (Rd !== 5'd5)    begin n_fail++; $display("FAIL alu_rd got=%0d exp=5", Rd); end
        n_tests++; if (Wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdata got=%h exp=deadbeef", Wr_data); end
        @(negedge clk); #1;
        n_tests++; if (rf[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_rf_x5 got=%h exp=deadbeef", rf[5]); end
        n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL alu_sberr got=%b exp=0", sb_err); end
    endtask

    task automatic test_round_robin;
        int          exp_idx [4] = '{0, 1, 2, 0};
        logic [31:0] dat     [3] = '{32'h0000_00A0, 32'h0000_00B1, 32'h0000_00C2};
        pulse_reset();
        do_issue(5'd1); do_issue(5'd1); do_issue(5'd2); do_issue(5'd3);
        @(negedge clk);
        set_req(REQ_ALU, 5'd1, dat[0]);
        set_req(REQ_LSU, 5'd2, dat[1]);
        set_req(REQ_MUL, 5'd3, dat[2]);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            n_tests++; if (req_ready !== 3'(1 << exp_idx[k]))
                begin n_fail++; $display("FAIL rr_ready[%0d] got=%b exp_idx=%0d", k, req_ready, exp_idx[k]); end
            @(posedge clk); #1;
            n_tests++; if (W_en !== 1'b1 || Rd !== 5'(exp_idx[k] + 1) || Wr_data !== dat[exp_idx[k]])
                begin n_fail++; $display("FAIL rr_write[%0d] got wen=%b rd=%0d data=%h exp rd=%0d data=%h",
                                         k, W_en, Rd, Wr_data, exp_idx[k] + 1, dat[exp_idx[k]]); end
        end
        req_valid = '0;
        n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL rr_sberr got=%b exp=0", sb_err); end
    endtask

    task automatic test_scoreboard;
        rs1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            do_issue(5'd7);
            n_tests++; if (issue_ready !== (k < 2))
                begin n_fail++; $display("FAIL sb_issue_ready[%0d] got=%b exp=%b", k, issue_ready, k < 2); end
        end
        n_tests++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_rs1_busy got=%b exp=1", rs1_busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_req(REQ_ALU, 5'd7, 32'h7000 + k);
            @(posedge clk); #1;
            req_valid = '0;
            n_tests++; if (rs1_busy !== (k < 2))
                begin n_fail++; $display("FAIL sb_retire_busy[%0d] got=%b exp=%b", k, rs1_busy, k < 2); end
        end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready_after got=%b exp=1", issue_ready); end
    endtask

    task automatic test_same_cycle;
        rs2 = 5'd9;
        do_issue(5'd9);
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd9;
        set_req(REQ_ALU, 5'd9, 32'h9999_0001);
        @(posedge clk); #1;
        issue_valid = 1'b0; req_valid = '0;
        n_tests++; if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL same_rs2_busy got=%b exp=1", rs2_busy); end
        @(negedge clk);
        set_req(REQ_ALU, 5'd9, 32'h9999_0002);
        @(posedge clk); #1;
        req_valid = '0;
        n_tests++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL same_rs2_clear got=%b exp=0", rs2_busy); end
        n_tests++; if (sb_err !== 1'b0)   begin n_fail++; $display("FAIL same_sberr got=%b exp=0", sb_err); end
    endtask

    task automatic test_underflow_x0;
        @(negedge clk);
        set_req(REQ_LSU, 5'd12, 32'h1212_1212);
        #1;
        n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL uf_ready got=%b exp=010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        n_tests++; if (sb_err !== 1'b1 || W_en !== 1'b1 || Rd !== 5'd12)
            begin n_fail++; $display("FAIL uf_write got sberr=%b wen=%b rd=%0d exp 1 1 12", sb_err, W_en, Rd); end
        @(posedge clk); #1;
        n_tests++; if (sb_err !== 1'b1 || W_en !== 1'b0 || Rd !== 5'd12 || Wr_data !== 32'h1212_1212)
            begin n_fail++; $display("FAIL uf_idle got sberr=%b wen=%b rd=%0d data=%h exp 1 0 12 12121212", sb_err, W_en, Rd, Wr_data); end
        rs1 = 5'd4;
        do_issue(5'd4);
        @(negedge clk);
        set_req(REQ_MUL, 5'd0, 32'h0000_FFFF);
        #1;
        n_tests++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL x0_ready got=%b exp=100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        n_tests++; if (W_en !== 1'b0 || Rd !== 5'd0 || Wr_data !== 32'h0000_FFFF)
            begin n_fail++; $display("FAIL x0_write got wen=%b rd=%0d data=%h exp 0 0 0000ffff", W_en, Rd, Wr_data); end
        n_tests++; if (rs1_busy !== 1'b1 || sb_err !== 1'b1)
            begin n_fail++; $display("FAIL x0_counters got busy=%b sberr=%b exp 1 1", rs1_busy, sb_err); end
    endtask

    task automatic test_reset_mid;
        rs1 = 5'd3;
        do_issue(5'd3); do_issue(5'd3); do_issue(5'd3);
        @(negedge clk);
        set_req(REQ_ALU, 5'd3, 32'h3333_3333);
        set_req(REQ_LSU, 5'd3, 32'h3333_4444);
        @(posedge clk); #1;
        n_tests++; if (W_en !== 1'b1 || rs1_busy !== 1'b1)
            begin n_fail++; $display("FAIL mid_before got wen=%b busy=%b exp 1 1", W_en, rs1_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (W_en !== 1'b0 || rs1_busy !== 1'b0 || sb_err !== 1'b0 || Rd !== 5'd0)
            begin n_fail++; $display("FAIL mid_reset got wen=%b busy=%b sberr=%b rd=%0d exp 0 0 0 0", W_en, rs1_busy, sb_err, Rd); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        test_reset();
        test_alu_only();
        test_round_robin();
        test_scoreboard();
        test_same_cycle();
        test_underflow_x0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
